down_counter_arbiter: RTL and testbench
=======================================

DOWN_COUNTER_ARBITER -- requirements
Module: down_counter_arbiter

Interface
REQ-001 Parameter N, 4, width of the shared down-count value and of each requester's load value.
REQ-002 Parameter NREQ, 4, number of requesters sharing the counter; legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  NREQ  per-requester request level; held high until the matching done pulse, or until the requester abandons.
REQ-006 data  input  NREQ*N  packed load values; requester i owns bits [i*N +: N].
REQ-007 gnt  output  NREQ  registered one-hot grant; all-zero when no requester owns the counter.
REQ-008 cnt  output  N  registered current count value.
REQ-009 busy  output  1  registered; high in COUNT and DONE states.
REQ-010 done  output  NREQ  registered one-hot completion pulse, exactly one cycle wide.

Function
REQ-011 The block SHALL use a three-state FSM: IDLE, COUNT, DONE.
REQ-012 In IDLE with req nonzero, at the next edge the block SHALL grant the first set req bit at or after rr_ptr, searching upward with wrap, and latch that requester's data into cnt.
REQ-013 The grant edge SHALL move the FSM to COUNT if the latched value is nonzero, else directly to DONE with cnt=0.
REQ-014 In COUNT, cnt SHALL decrement by 1 per edge; the edge that makes cnt 0 SHALL move the FSM to DONE.
REQ-015 In DONE, done[winner] SHALL be high for that one cycle; the next edge SHALL clear gnt and done, return to IDLE, and set rr_ptr to winner+1 modulo NREQ.
REQ-016 Latency: a value D granted at edge k SHALL give done high in the cycle after edge k+D; D=0 SHALL give done in the cycle after edge k.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants.
REQ-018 cnt SHALL never wrap below 0; it SHALL hold its value in IDLE.
REQ-019 data changes after the grant edge SHALL NOT affect the count in progress.
REQ-020 New req assertions during COUNT or DONE SHALL wait and SHALL NOT pre-empt the current owner.
REQ-021 In IDLE with req all-zero, the FSM SHALL stay in IDLE, with gnt=0 and cnt, rr_ptr unchanged.

Reset
REQ-022 While rst_n is low at an edge: FSM=IDLE, gnt=0, done=0, busy=0, cnt=0, rr_ptr=0.
REQ-023 Reset mid-COUNT or mid-DONE SHALL abandon the operation with no done pulse.
REQ-024 Arbitration after reset release SHALL start from requester 0.

Configuration
REQ-025 Macro DOWN_COUNTER_ARBITER_ABORT_EN SHALL control requester abandonment.
REQ-026 With DOWN_COUNTER_ARBITER_ABORT_EN defined, req[winner] low at an edge in COUNT SHALL return the FSM to IDLE, clear gnt, and set rr_ptr=winner+1, with no done pulse and cnt left at its current value.
REQ-027 Without the macro, req deassertion after the grant SHALL be ignored; the count SHALL complete and done SHALL still pulse.

Verification
REQ-028 Reset, then req=4'b0010, data[7:4]=3 -> gnt=0010; cnt sequence 3,2,1,0; done=0010 for one cycle 3 cycles after the grant edge; rr_ptr=2.
REQ-029 req=4'b1111 held continuously, all data=1 -> grants in order 0001,0010,0100,1000,0001, with one IDLE cycle between grants.
REQ-030 data=0 for requester 3 only requesting -> FSM goes IDLE to DONE; done=1000 in the cycle after the grant edge; cnt=0.
REQ-031 Requester 0 granted with data=15, rst_n low at cnt=9 -> next cycle gnt=0, cnt=0, busy=0, and no done pulse.
REQ-032 With the macro defined, requester 1 granted with data=8, req[1] dropped at cnt=5 -> IDLE, no done, and a pending req[2] granted next. Without the macro, the same stimulus -> count reaches 0 and done=0010.
REQ-033 data changed to 15 mid-count of value 4 -> done pulses on the original schedule.

Source files
------------

// File: rtl/down_counter_arbiter.sv
// ============================================================================
// Module      : down_counter_arbiter
// Description : Round-robin arbiter in front of one shared down-counter.
//               An idle block grants the first requesting port at or after
//               the round-robin pointer and loads that port's value. It then
//               counts down to zero and pulses that port's done bit for one
//               cycle. The block always returns to IDLE for at least one
//               cycle between two grants.
// Ports       : clk     - clock; all state changes on the rising edge
//               rst_n   - synchronous active-low reset
//               req_i   - per-requester request level [NREQ]
//               data_i  - packed load values, requester i owns [i*N +: N]
//               gnt_o   - registered one-hot grant (zero when no owner)
//               cnt_o   - registered current count value
//               busy_o  - registered, high in COUNT and DONE
//               done_o  - registered one-hot, one-cycle completion pulse
// Options     : DOWN_COUNTER_ARBITER_ABORT_EN - when defined, the owner can
//               abandon a count by dropping its request while the block is
//               counting. The block then returns to IDLE with no done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*N-1:0]    data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [N-1:0]         cnt_o,
    output logic                 busy_o,
    output logic [NREQ-1:0]      done_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [N-1:0]  CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW:0]   SUM_WRAP = (IW+1)'(NREQ);
    localparam logic [IW-1:0] WIN_LAST = IW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [N-1:0]    cnt_q,   cnt_d;
    logic            busy_q,  busy_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [IW-1:0]   win_q,   win_d;
    logic [IW-1:0]   rr_q,    rr_d;

    // ------------------------------------------------------------------
    // Round-robin pick. Duplicate the request vector and shift it right by
    // the pointer, so the lowest set bit is the offset from rr_q to the
    // winner, with wrap-around included.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0] w_req_dbl;
    logic [2*NREQ-1:0] w_req_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;
    logic [IW:0]       w_sum_wrapped;
    logic [IW-1:0]     w_pick;
    logic [NREQ-1:0]   w_pick_onehot;
    logic [N-1:0]      w_load;
    logic [IW-1:0]     w_rr_next;
    logic              w_abort;

    assign w_req_dbl = {req_i, req_i};
    assign w_req_rot = w_req_dbl >> rr_q;

    always_comb begin
        w_off = '0;
        // Scan downwards so that the lowest set bit is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum         = {1'b0, rr_q} + {1'b0, w_off};
    assign w_sum_wrapped = (w_sum >= SUM_WRAP) ? (w_sum - SUM_WRAP) : w_sum;
    assign w_pick        = w_sum_wrapped[IW-1:0];

    always_comb begin
        w_pick_onehot = '0;
        w_load        = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick == IW'(k)) begin
                w_pick_onehot[k] = 1'b1;
                w_load           = data_i[k*N +: N];
            end
        end
    end

    assign w_rr_next = (win_q == WIN_LAST) ? '0 : (win_q + 1'b1);

`ifdef DOWN_COUNTER_ARBITER_ABORT_EN
    // gnt_q is one-hot on the winner, so this tests req_i[winner].
    assign w_abort = ~|(req_i & gnt_q);
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        win_d   = win_q;
        rr_d    = rr_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    win_d = w_pick;
                    gnt_d = w_pick_onehot;
                    cnt_d = w_load;
                    // A zero load skips COUNT, so done follows the grant at once.
                    if (w_load == '0) begin
                        state_d = ST_DONE;
                        done_d  = w_pick_onehot;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end

            ST_COUNT: begin
                if (w_abort) begin
                    // cnt is deliberately left at its current value.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = w_rr_next;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        done_d  = gnt_q;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                rr_d    = w_rr_next;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            win_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter_arbiter.sv
// ============================================================================
// Module      : tb_down_counter_arbiter
// Description : Self-checking bench for down_counter_arbiter. It uses a
//               vector table, hand-written corner sequences and randomized
//               traffic checked against a transaction-level model.
//               DOWN_COUNTER_ARBITER_ABORT_EN selects the abandonment
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;
`ifdef DOWN_COUNTER_ARBITER_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      cnt;
    logic              busy;
    logic [NREQ-1:0]   done;

    down_counter_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req),
        .data_i (data),
        .gnt_o  (gnt),
        .cnt_o  (cnt),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model. An owner holds the counter from its grant edge
    // g until edge g+D+1. The count after edge e is g+D-e, and done is seen
    // after edge g+D.
    int m_e        = 0;
    int m_own      = -1;
    int m_cnt      = 0;
    int m_rr       = 0;
    int m_deadline = 0;

    task automatic model_edge();
        int w;
        m_e++;
        if (!rst_n) begin
            m_own = -1;
            m_cnt = 0;
            m_rr  = 0;
        end else if (m_own < 0) begin
            if (req != '0) begin
                w = 0;
                for (int off = NREQ - 1; off >= 0; off--) begin
                    if (req[(m_rr + off) % NREQ]) w = (m_rr + off) % NREQ;
                end
                m_own      = w;
                m_cnt      = int'((data >> (w * N)) & 16'hF);
                m_deadline = m_e + m_cnt;
            end
        end else if (m_e == m_deadline + 1) begin
            m_rr  = (m_own + 1) % NREQ;
            m_own = -1;
        end else if (ABORT && !req[m_own] && m_e <= m_deadline) begin
            m_rr  = (m_own + 1) % NREQ;
            m_own = -1;
        end else begin
            m_cnt = m_deadline - m_e;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_done;
        logic            e_busy;
        logic [N-1:0]    e_cnt;
        e_gnt  = '0;
        e_done = '0;
        e_busy = 1'b0;
        e_cnt  = N'(m_cnt);
        if (m_own >= 0) begin
            e_gnt  = NREQ'(1) << m_own;
            e_busy = 1'b1;
            if (m_e == m_deadline) e_done = e_gnt;
        end
        check("model{gnt,cnt,busy,done}", {19'd0, gnt, cnt, busy, done},
              {19'd0, e_gnt, e_cnt, e_busy, e_done});
    endtask

    task automatic step(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*N-1:0] d);
        rst_n = r;
        req   = q;
        data  = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic              rst_n;
        logic [NREQ-1:0]   req;
        logic [NREQ*N-1:0] data;
        logic [NREQ-1:0]   gnt;
        logic [N-1:0]      cnt;
        logic              busy;
        logic [NREQ-1:0]   done;
    } vec_t;

    vec_t tbl [23];

    initial begin
        bit hit;
        rst_n = 1'b0;
        req   = '0;
        data  = '0;

        // Reset, one 3-count, one zero-load grant, then a full round-robin sweep
        tbl[0]  = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd3, 1'b1, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd2, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd1, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0010, 16'h0030, 4'b0010, 4'd0, 1'b1, 4'b0010};
        tbl[5]  = '{1'b1, 4'b0000, 16'h0030, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 4'b1000, 16'h0000, 4'b1000, 4'd0, 1'b1, 4'b1000};
        tbl[7]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[8]  = '{1'b1, 4'b1111, 16'h1111, 4'b0001, 4'd1, 1'b1, 4'b0000};
        tbl[9]  = '{1'b1, 4'b1111, 16'h1111, 4'b0001, 4'd0, 1'b1, 4'b0001};
        tbl[10] = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[11] = '{1'b1, 4'b1111, 16'h1111, 4'b0010, 4'd1, 1'b1, 4'b0000};
        tbl[12] = '{1'b1, 4'b1111, 16'h1111, 4'b0010, 4'd0, 1'b1, 4'b0010};
        tbl[13] = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[14] = '{1'b1, 4'b1111, 16'h1111, 4'b0100, 4'd1, 1'b1, 4'b0000};
        tbl[15] = '{1'b1, 4'b1111, 16'h1111, 4'b0100, 4'd0, 1'b1, 4'b0100};
        tbl[16] = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[17] = '{1'b1, 4'b1111, 16'h1111, 4'b1000, 4'd1, 1'b1, 4'b0000};
        tbl[18] = '{1'b1, 4'b1111, 16'h1111, 4'b1000, 4'd0, 1'b1, 4'b1000};
        tbl[19] = '{1'b1, 4'b1111, 16'h1111, 4'b0000, 4'd0, 1'b0, 4'b0000};
        tbl[20] = '{1'b1, 4'b1111, 16'h1111, 4'b0001, 4'd1, 1'b1, 4'b0000};
        tbl[21] = '{1'b1, 4'b1111, 16'h1111, 4'b0001, 4'd0, 1'b1, 4'b0001};
        tbl[22] = '{1'b1, 4'b0000, 16'h1111, 4'b0000, 4'd0, 1'b0, 4'b0000};

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].data);
            check($sformatf("vec%0d{gnt,cnt,busy,done}", i),
                  {19'd0, gnt, cnt, busy, done},
                  {19'd0, tbl[i].gnt, tbl[i].cnt, tbl[i].busy, tbl[i].done});
        end

        // Load of 4, then the data changes to 15: done must still arrive 4 edges on
        step(1'b1, 4'b0001, 16'h0004);
        check("dchg_grant_cnt", 32'(cnt), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'b0001, 16'hFFFF);
            if (i == 3) check("dchg_no_early_done", 32'(done), 32'd0);
            if (i == 4) check("dchg_done_on_time", 32'(done), 32'b0001);
        end
        step(1'b1, 4'b0000, 16'hFFFF);

        // Reset during a count of 15, applied once cnt shows 9
        step(1'b0, 4'b0000, 16'h0000);
        step(1'b1, 4'b0001, 16'h000F);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (cnt == 4'd9) hit = 1'b1;
            else step(1'b1, 4'b0001, 16'h000F);
        end
        check("rst_wait_cnt9", 32'(hit), 32'd1);
        step(1'b0, 4'b0001, 16'h000F);
        check("rst_mid{gnt,cnt,busy,done}", {21'd0, gnt, cnt, busy, done}, 32'd0);
        step(1'b1, 4'b0000, 16'h000F);
        check("rst_mid_no_done", 32'(done), 32'd0);

        // Requester 1 loads 8 and drops its request at cnt=5, with requester 2 pending
        step(1'b1, 4'b0110, 16'h0280);
        check("abort_grant", 32'(gnt), 32'b0010);
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (cnt == 4'd5) hit = 1'b1;
            else step(1'b1, 4'b0110, 16'h0280);
        end
        check("abort_wait_cnt5", 32'(hit), 32'd1);
        step(1'b1, 4'b0100, 16'h0280);
`ifdef DOWN_COUNTER_ARBITER_ABORT_EN
        check("abort_idle{gnt,cnt,busy,done}", {19'd0, gnt, cnt, busy, done},
              {19'd0, 4'b0000, 4'd5, 1'b0, 4'b0000});
        step(1'b1, 4'b0100, 16'h0280);
        check("abort_next_grant", 32'(gnt), 32'b0100);
`else
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (done != '0) hit = 1'b1;
            else step(1'b1, 4'b0100, 16'h0280);
        end
        check("noabort_done_seen", 32'(hit), 32'd1);
        check("noabort_done", 32'(done), 32'b0010);
        check("noabort_cnt0", 32'(cnt), 32'd0);
`endif

        // Randomized traffic against the model
        step(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            logic [NREQ-1:0] q;
            q = req;
            if ($urandom_range(0, 3) == 0) q = NREQ'($urandom);
            step(($urandom_range(0, 59) != 0), q, (NREQ*N)'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
